// File: rtl/alu_op_issue_if.sv
// Operand-issue bus between register-file read, the decode/issue stage and the ALU.
// The master drives the upstream entry and the downstream ready; the slave is the issue stage.
interface alu_op_issue_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_rs1_val;
    logic [XLEN-1:0] in_rs2_val;

    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_alu_op;
    logic [XLEN-1:0] out_ina;
    logic [XLEN-1:0] out_inb;
    logic [4:0]      out_rd;
    logic            out_illegal;

    modport master (
        output in_valid,
        output in_instr,
        output in_rs1_val,
        output in_rs2_val,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_alu_op,
        input  out_ina,
        input  out_inb,
        input  out_rd,
        input  out_illegal
    );

    modport slave (
        input  in_valid,
        input  in_instr,
        input  in_rs1_val,
        input  in_rs2_val,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_alu_op,
        output out_ina,
        output out_inb,
        output out_rd,
        output out_illegal
    );
endinterface

// File: rtl/alu_op_issue.sv
// Decode/issue stage: decodes RV32I instructions into ALU op + operands and
// holds them in a two-entry skid buffer (main + skid) so in_ready is a flop.
module alu_op_issue #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    alu_op_issue_if.slave bus
);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpXor  = 4'b0011;
    localparam logic [3:0] OpSll  = 4'b0100;
    localparam logic [3:0] OpSrl  = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSltu = 4'b0111;
    localparam logic [3:0] OpSlt  = 4'b1000;
    localparam logic [3:0] OpSra  = 4'b1001;

    localparam logic [6:0] OpcReg    = 7'b0110011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3SrlSra = 3'b101;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic [XLEN-1:0] ina;
        logic [XLEN-1:0] inb;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q;
    entry_t dec;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            f7_zero;
    logic            f7_alt;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] shamt_rs2;
    logic [XLEN-1:0] shamt_imm;
    logic            in_xfer;
    logic            out_xfer;
    logic            unused_rs1_idx;

    assign opcode  = bus.in_instr[6:0];
    assign funct3  = bus.in_instr[14:12];
    assign funct7  = bus.in_instr[31:25];
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    assign imm_i     = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign imm_s     = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
    assign shamt_rs2 = {{(XLEN-SHAMT_W){1'b0}}, bus.in_rs2_val[SHAMT_W-1:0]};
    assign shamt_imm = {{(XLEN-SHAMT_W){1'b0}}, bus.in_instr[20 +: SHAMT_W]};

    // rs1 index is resolved by the register file; only its value reaches this stage.
    assign unused_rs1_idx = ^bus.in_instr[19:15];

    // funct3 -> ALU op; alt selects sub/sra on the two funct3 codes that have a variant.
    function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? OpSub : OpAdd;
            3'b001:  op = OpSll;
            3'b010:  op = OpSlt;
            3'b011:  op = OpSltu;
            3'b100:  op = OpXor;
            3'b101:  op = alt ? OpSra : OpSrl;
            3'b110:  op = OpOr;
            default: op = OpAnd;
        endcase
        return op;
    endfunction

    // Decode the incoming instruction into an issue entry.
    always_comb begin
        dec         = '0;
        dec.alu_op  = OpAdd;
        dec.ina     = bus.in_rs1_val;
        dec.inb     = bus.in_rs2_val;
        dec.rd      = bus.in_instr[11:7];
        dec.illegal = 1'b0;
        case (opcode)
            OpcReg: begin
                dec.alu_op = f3_op(funct3, f7_alt);
                if (funct3 == F3Sll || funct3 == F3SrlSra) begin
                    dec.inb = shamt_rs2;
                end
                // Only 0100000 variants are sub and sra; everything else needs funct7 == 0.
                if (!(f7_zero || (f7_alt && (funct3 == F3AddSub || funct3 == F3SrlSra)))) begin
                    dec.illegal = 1'b1;
                end
            end
            OpcImm: begin
                dec.alu_op = f3_op(funct3, 1'b0);
                dec.inb    = imm_i;
                if (funct3 == F3Sll) begin
                    dec.inb     = shamt_imm;
                    dec.illegal = !f7_zero;
                end else if (funct3 == F3SrlSra) begin
                    dec.inb     = shamt_imm;
                    dec.alu_op  = f7_alt ? OpSra : OpSrl;
                    dec.illegal = !(f7_zero || f7_alt);
                end
            end
            OpcLoad: begin
                dec.inb = imm_i;
            end
            OpcStore: begin
                dec.inb = imm_s;
                dec.rd  = '0;
            end
            OpcBranch: begin
                dec.rd = '0;
                case (funct3[2:1])
                    2'b00:   dec.alu_op = OpSub;
                    2'b10:   dec.alu_op = OpSlt;
                    2'b11:   dec.alu_op = OpSltu;
                    default: dec.illegal = 1'b1;
                endcase
            end
            // Unknown opcodes still issue; EX raises the trap.
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign in_xfer  = bus.in_valid & in_ready_q;
    assign out_xfer = (state_q != StEmpty) & bus.out_ready;

    // Skid-buffer occupancy and entry movement.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d = StOne;
                    main_d  = dec;
                end
            end
            StOne: begin
                if (in_xfer && !out_xfer) begin
                    state_d = StTwo;
                    skid_d  = dec;
                end else if (in_xfer && out_xfer) begin
                    main_d = dec;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (out_xfer) begin
                    state_d = StOne;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
        // Redirect drops everything, including an entry accepted this cycle.
        if (flush) begin
            state_d = StEmpty;
        end
    end

    // State, buffered entries and registered ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != StTwo);
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (state_q != StEmpty);
    assign bus.out_alu_op  = main_q.alu_op;
    assign bus.out_ina     = main_q.ina;
    assign bus.out_inb     = main_q.inb;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_illegal = main_q.illegal;

endmodule
